// File: rtl/fir_stream_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fir_stream_sequencer_pkg
//   Shared definitions for the FIR stream sequencer: FSM state encoding,
//   default FIR sample widths (shared with the FIR and its bench) and a
//   helper that sizes counters from their maximum value.
// ---------------------------------------------------------------------------
package fir_stream_sequencer_pkg;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_OUTPUT_WIDTH = 38;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_CHECK    = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_e;

  // Number of bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fir_seq_timer.sv
// ---------------------------------------------------------------------------
// fir_seq_timer
//   Loadable down-counter with a terminal flag. Used by the sequencer for the
//   inter-sample gap and for the FIR response timeout.
// Ports
//   clk         in   clock, rising edge
//   reset       in   async active-low reset (counter -> 0)
//   load        in   load load_value (has priority over dec)
//   load_value  in   WIDTH  value to load
//   dec         in   decrement by one; holds at zero
//   terminal    out  counter is zero
// ---------------------------------------------------------------------------
module fir_seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == '0);

endmodule

// File: rtl/fir_stream_sequencer.sv
// ---------------------------------------------------------------------------
// fir_stream_sequencer
//   On-chip stimulus/check engine for a FIR filter. Reads input samples and
//   expected results from two sync-read ROMs sharing one address, pulses each
//   sample into the FIR, waits (bounded) for the FIR result, compares it with
//   the expected value and keeps mismatch/sample counters and error flags.
// Ports
//   clk, reset      clock (rising edge), async active-low reset
//   start           1-cycle run request, honoured only when idle or done
//   rom_addr        shared ROM address (ROM data valid one cycle later)
//   in_rom_data     input sample from ROM
//   exp_rom_data    expected FIR output from ROM
//   fir_din         sample to FIR, held until the next issue
//   fir_in_valid    1-cycle pulse per sample
//   fir_dout        FIR result
//   fir_out_valid   FIR result strobe
//   busy / done     run in progress / run finished (done held until start)
//   mismatch        1-cycle pulse per compare failure
//   err_count       saturating mismatch count for this run
//   sample_count    samples checked this run
//   timeout_err     sticky: run aborted because the FIR never answered
//   spurious_err    sticky: fir_out_valid seen while not waiting for it
// ---------------------------------------------------------------------------
module fir_stream_sequencer
  import fir_stream_sequencer_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int LENGTH       = 221184,
  parameter int ADDR_WIDTH   = 18,
  parameter int GAP_CYCLES   = 5,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [INPUT_WIDTH-1:0]  in_rom_data,
  input  logic [OUTPUT_WIDTH-1:0] exp_rom_data,
  output logic [INPUT_WIDTH-1:0]  fir_din,
  output logic                    fir_in_valid,
  input  logic [OUTPUT_WIDTH-1:0] fir_dout,
  input  logic                    fir_out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic [ADDR_WIDTH:0]     err_count,
  output logic [ADDR_WIDTH:0]     sample_count,
  output logic                    timeout_err,
  output logic                    spurious_err
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int TMO_W = cnt_width(TIMEOUT);

  // The gap timer counts down to zero while in GAP, so loading N-1 yields N
  // GAP cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  // The timeout window is measured from the fir_in_valid pulse (the ISSUE
  // cycle is elapsed cycle 0). Loading TIMEOUT-2 makes the timer reach zero
  // in the WAIT_OUT cycle that is TIMEOUT-1 cycles after the pulse, so DONE
  // is entered exactly TIMEOUT cycles after it. TIMEOUT=1 gives up after
  // the first WAIT_OUT cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT > 1) ? TMO_W'(TIMEOUT - 2) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX   = '1;

  seq_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [INPUT_WIDTH-1:0]  fir_din_q, fir_din_d;
  logic [OUTPUT_WIDTH-1:0] exp_q, exp_d;
  logic [OUTPUT_WIDTH-1:0] cap_q, cap_d;
  logic [ADDR_WIDTH:0]     err_count_q, err_count_d;
  logic [ADDR_WIDTH:0]     sample_count_q, sample_count_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    spurious_err_q, spurious_err_d;

  logic gap_load, gap_dec, gap_term;
  logic tmo_load, tmo_dec, tmo_term;
  logic mismatch_c;

  fir_seq_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .terminal   (gap_term)
  );

  fir_seq_timer #(.WIDTH(TMO_W)) u_tmo_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmo_load),
    .load_value (TMO_LOAD),
    .dec        (tmo_dec),
    .terminal   (tmo_term)
  );

  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    fir_din_d      = fir_din_q;
    exp_d          = exp_q;
    cap_d          = cap_q;
    err_count_d    = err_count_q;
    sample_count_d = sample_count_q;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q;
    gap_load       = 1'b0;
    gap_dec        = 1'b0;
    tmo_load       = 1'b0;
    tmo_dec        = 1'b0;
    mismatch_c     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_FETCH;
          rom_addr_d     = '0;
          err_count_d    = '0;
          sample_count_d = '0;
          timeout_err_d  = 1'b0;
          spurious_err_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        fir_din_d = in_rom_data;
        exp_d     = exp_rom_data;
        tmo_load  = 1'b1;
        state_d   = ST_WAIT_OUT;
      end
      ST_WAIT_OUT: begin
        if (fir_out_valid) begin
          cap_d   = fir_dout;
          state_d = ST_CHECK;
        end else if (tmo_term) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        sample_count_d = sample_count_q + 1'b1;
        if (cap_q != exp_q) begin
          mismatch_c = 1'b1;
          if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + 1'b1;
          end
        end
        if (rom_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_FETCH;
          end else begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_term) begin
          state_d = ST_FETCH;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A result strobe outside WAIT_OUT is never consumed; flag it. Placed
    // after the start clear so a strobe in the start cycle is still reported.
    if (fir_out_valid && (state_q != ST_WAIT_OUT)) begin
      spurious_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      rom_addr_q     <= '0;
      fir_din_q      <= '0;
      exp_q          <= '0;
      cap_q          <= '0;
      err_count_q    <= '0;
      sample_count_q <= '0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      fir_din_q      <= fir_din_d;
      exp_q          <= exp_d;
      cap_q          <= cap_d;
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

  // The ROM word only arrives in ISSUE, the same cycle as the valid pulse,
  // so it is forwarded straight through; fir_din_q holds it afterwards.
  assign fir_in_valid = (state_q == ST_ISSUE);
  assign fir_din      = fir_in_valid ? in_rom_data : fir_din_q;
  assign rom_addr     = rom_addr_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign mismatch     = mismatch_c;
  assign err_count    = err_count_q;
  assign sample_count = sample_count_q;
  assign timeout_err  = timeout_err_q;
  assign spurious_err = spurious_err_q;

endmodule
